// File: rtl/spi_pkg.sv
// spi_pkg
//   Shared definitions for the 4-command SPI RAM link. The master in this
//   directory and the slave FSM both take their opcodes, widths and state
//   encoding from here.
//   No ports; imported with "import spi_pkg::*".
package spi_pkg;

    localparam int WORD_W = 10;
    localparam int DATA_W = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RECV  = 3'd4,
        ST_END   = 3'd5
    } state_t;

    // Bit 1 of the opcode is the direction bit sent in the START cycle.
    function automatic logic op_is_read(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/spi_ram_master_if.sv
// spi_ram_master_if
//   Bundles the local command/response port and the SPI pins of the master.
//   Signals:
//     cmd_valid/cmd_ready/cmd_op/cmd_data  command request (one at a time)
//     busy                                 master is mid-frame
//     rsp_valid/rsp_data                   read-data reply pulse
//     SS_n/MOSI/MISO                       SPI frame select and data lines
//   Modports:
//     master  the SPI master's view (drives SS_n/MOSI, responses)
//     slave   the far side (drives commands and MISO)
interface spi_ram_master_if;
    import spi_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              busy;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              SS_n;
    logic              MOSI;
    logic              MISO;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, MISO,
        output cmd_ready, busy, rsp_valid, rsp_data, SS_n, MOSI
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, MISO,
        input  cmd_ready, busy, rsp_valid, rsp_data, SS_n, MOSI
    );

endinterface

// File: rtl/spi_shifter.sv
// spi_shifter
//   Parallel-load TX shift register (WORD_W bits, shifts out MSB first) and
//   RX shift register (DATA_W bits, shifts in at the LSB so the first bit
//   received ends up as the MSB).
//   Ports:
//     clk, rst   clock, synchronous active-high reset (clears both registers)
//     load       load tx_word into the TX register
//     tx_en      shift the TX register left by one
//     tx_word    parallel word to transmit
//     tx_msb     current TX MSB (next bit to put on the line)
//     rx_en      shift rx_bit into the RX register
//     rx_bit     serial input bit
//     rx_next    RX contents after this cycle's shift, so the caller can
//                capture the full byte on the same edge as the last bit
module spi_shifter
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              tx_en,
    input  logic [WORD_W-1:0] tx_word,
    output logic              tx_msb,
    input  logic              rx_en,
    input  logic              rx_bit,
    output logic [DATA_W-1:0] rx_next
);

    logic [WORD_W-1:0] tx_reg;
    logic [DATA_W-1:0] rx_reg;

    assign tx_msb  = tx_reg[WORD_W-1];
    assign rx_next = (rx_reg << 1) | DATA_W'(rx_bit);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_reg <= '0;
        end else if (load) begin
            tx_reg <= tx_word;
        end else if (tx_en) begin
            tx_reg <= tx_reg << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_reg <= '0;
        end else if (rx_en) begin
            rx_reg <= rx_next;
        end
    end

endmodule

// File: rtl/spi_ram_master.sv
// spi_ram_master
//   SPI master for the 4-command SPI RAM protocol. Accepts one command at a
//   time, sends {cmd_op, cmd_data} MSB first after a direction bit, and for
//   read-data commands waits RD_WAIT cycles then collects an 8-bit reply.
//   Every output comes straight from a flop loaded from the next-state
//   decode, so outputs for a state appear during that state.
//   Ports:
//     clk, rst   system clock, synchronous active-high reset
//     bus        spi_ram_master_if.master (command, response, SPI pins)
//   Parameter:
//     RD_WAIT    idle cycles between last MOSI bit and first MISO sample,
//                legal 1..15
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | SS_n high, cmd_ready high, waiting for cmd_valid
//   ST_START | SS_n low, MOSI = direction bit, one cycle
//   ST_SHIFT | ten word bits on MOSI, cnt 0..9
//   ST_WAIT  | read-data turnaround, RD_WAIT cycles, MOSI low
//   ST_RECV  | eight MISO samples into the RX register, cnt 0..7
//   ST_END   | SS_n high, one cycle; rsp_valid pulse for read-data
module spi_ram_master
    import spi_pkg::*;
#(
    parameter int unsigned RD_WAIT = 2
) (
    input logic              clk,
    input logic              rst,
    spi_ram_master_if.master bus
);

    localparam logic [3:0] SHIFT_LAST = 4'(WORD_W - 1);
    localparam logic [3:0] WAIT_LAST  = 4'(RD_WAIT - 1);
    localparam logic [3:0] RECV_LAST  = 4'(DATA_W - 1);

    state_t            state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic              rd_op, rd_op_d;

    logic              load, tx_en, rx_en;
    logic              tx_msb;
    logic [DATA_W-1:0] rx_next;

    logic              ss_n_d, mosi_d, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_d;

    logic              ss_n_q, mosi_q, cmd_ready_q, busy_q, rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;

    spi_shifter u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .tx_en   (tx_en),
        .tx_word ({bus.cmd_op, bus.cmd_data}),
        .tx_msb  (tx_msb),
        .rx_en   (rx_en),
        .rx_bit  (bus.MISO),
        .rx_next (rx_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rd_op <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            rd_op <= rd_op_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        rd_op_d     = rd_op;
        load        = 1'b0;
        tx_en       = 1'b0;
        rx_en       = 1'b0;
        ss_n_d      = 1'b1;
        mosi_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        unique case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    load    = 1'b1;
                    rd_op_d = (bus.cmd_op == OP_RD_DATA);
                    cnt_d   = '0;
                    ss_n_d  = 1'b0;
                    mosi_d  = op_is_read(bus.cmd_op);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Word MSB goes out now; the register then exposes the next bit.
                ss_n_d  = 1'b0;
                mosi_d  = tx_msb;
                tx_en   = 1'b1;
                cnt_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                ss_n_d = 1'b0;
                if (cnt == SHIFT_LAST) begin
                    cnt_d = '0;
                    if (rd_op) begin
                        state_d = ST_WAIT;
                    end else begin
                        ss_n_d  = 1'b1;
                        state_d = ST_END;
                    end
                end else begin
                    cnt_d  = cnt + 4'd1;
                    mosi_d = tx_msb;
                    tx_en  = 1'b1;
                end
            end
            ST_WAIT: begin
                ss_n_d = 1'b0;
                if (cnt == WAIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RECV;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            ST_RECV: begin
                ss_n_d = 1'b0;
                rx_en  = 1'b1;
                if (cnt == RECV_LAST) begin
                    // Last bit lands on this edge; capture the completed byte.
                    cnt_d       = '0;
                    ss_n_d      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_next;
                    state_d     = ST_END;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            ST_END: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            busy_q      <= (state_d != ST_IDLE);
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.SS_n      = ss_n_q;
    assign bus.MOSI      = mosi_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: doc/spi_ram_master.md
# spi_ram_master

Single-clock SPI master: the initiating end of the team's 4-command SPI RAM protocol. It takes one command at a time from a local valid/ready port and serialises it MSB-first onto MOSI under an SS_n frame. For read-data commands it deserialises the 8-bit reply from MISO. It sits on the system side of the link and drives the SPI RAM slave wrapper in benches and in the loop-back top level, on the same clk as the slave.

## Interface
- RD_WAIT, 2: idle cycles between the last MOSI bit and the first MISO sample of a read-data frame; legal range 1..15.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  command code: 00 write-address, 01 write-data, 10 read-address, 11 read-data.
- cmd_data  in  8  payload; for op 11 it is sent as dummy bits.
- busy  out  1  high whenever the state is not IDLE.
- rsp_valid  out  1  one-cycle pulse carrying read data.
- rsp_data  out  8  read byte; holds its value until the next rsp_valid.
- SS_n  out  1  active-low frame select.
- MOSI  out  1  serial data to the slave.
- MISO  in  1  serial data from the slave.

## Operation
- States: IDLE, START, SHIFT, WAIT, RECV, END.
- IDLE:
  - SS_n=1, MOSI=0, cmd_ready=1.
  - On cmd_valid&cmd_ready, latch word = {cmd_op, cmd_data} (10 bits) and go to START.
  - cmd_op and cmd_data are sampled only at acceptance.
- START: 1 cycle. SS_n=0, MOSI=cmd_op[1] (direction bit: 0 write, 1 read). Go to SHIFT.
- SHIFT:
  - 10 cycles. MOSI = word[9] down to word[0], one bit per cycle. A 4-bit counter runs 0..9.
  - After the 10th bit: op 11 goes to WAIT; all other ops go to END.
- WAIT: RD_WAIT cycles. SS_n=0, MOSI=0. Go to RECV.
- RECV:
  - 8 cycles. Sample MISO on each rising edge and shift it into rx_shift, MSB first. SS_n=0, MOSI=0.
  - Go to END.
- END:
  - 1 cycle. SS_n=1, MOSI=0.
  - For op 11: rsp_valid=1 and rsp_data = the assembled byte in this cycle.
  - Go to IDLE.
- Every output is driven from a register; there are no combinational paths from any input to any output.
- Reset values: SS_n=1, MOSI=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=8'h00. State=IDLE, counters=0.
- Reset mid-frame: at the reset edge SS_n goes high and the frame is aborted. No rsp_valid is produced and rx_shift is cleared.
- cmd_valid outside IDLE is ignored: no queuing, no error flag.

## Timing
- Cycle A = acceptance edge. The cycles below are when the registered outputs hold each value.
- A+1: SS_n low, MOSI = direction bit.
- A+2..A+11: the 10 word bits.
- Write and read-address frames: END at A+12. cmd_ready is high again at A+13, giving 13 cycles accept-to-accept.
- Read-data frame:
  - WAIT at A+12..A+11+RD_WAIT.
  - MISO sampled over the 8 RECV cycles, A+12+RD_WAIT..A+19+RD_WAIT.
  - END at A+20+RD_WAIT, with the rsp_valid pulse in that same cycle.
  - With RD_WAIT=2: rsp_valid at A+22, next accept at A+23.
- SS_n is high for at least 2 cycles between frames (END plus the IDLE accept cycle).

## Structure
- Shared package spi_pkg:
  - opcode localparams OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11;
  - state encoding;
  - widths: WORD_W=10, DATA_W=8.
- spi_pkg is the single source of truth for the slave FSM and this master.
- One natural sub-module, spi_shifter: a parallel-load 10-bit TX shift register plus an 8-bit RX shift register, with load/shift enables. It is instantiated once.

## Test plan
- Reset: hold rst for 3 cycles mid-SHIFT -> SS_n=1 and cmd_ready=1 the cycle after release, no rsp_valid.
- Write-address, cmd_data=8'hA5 -> MOSI sequence 0, 0,0,1,0,1,0,0,1,0,1. SS_n low for exactly 11 cycles.
- Write-data 8'h3C, then read-address 8'hA5, then read-data, all against the slave wrapper + RAM -> rsp_valid one cycle with rsp_data=8'h3C at A+22.
- Read-data with MISO modelled as constant 8'hC3 after RD_WAIT=2 -> rsp_data=8'hC3. Repeat with RD_WAIT=5 -> pulse at A+25.
- Back-to-back cmd_valid held high for 4 writes -> accepts exactly 13 cycles apart. cmd_ready is low throughout each frame, and SS_n is high at least 2 cycles between frames.
- cmd_valid pulsed while busy -> ignored; frame count and MOSI stream unchanged.
